// File: rtl/wavegen_pkg.sv
// Shared encodings for the waveform-generator sweep controller.
package wavegen_pkg;

  localparam int STEP_WIDTH_DEF = 12;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'd0,
    MODE_REPEAT = 2'd1,
    MODE_UPDOWN = 2'd2
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // The reserved encoding runs as a single sweep.
  function automatic mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return MODE_REPEAT;
      2'd2:    return MODE_UPDOWN;
      default: return MODE_SINGLE;
    endcase
  endfunction

endpackage

// File: rtl/wavegen_sweep_ctrl_if.sv
// Config/control bus between the register block and the sweep controller,
// plus the strobed step/range feed towards the wave generator.
interface wavegen_sweep_ctrl_if #(
  parameter int STEP_WIDTH  = 12,
  parameter int DWELL_WIDTH = 16,
  parameter int COUNT_WIDTH = 16
);

  logic [STEP_WIDTH-1:0]  cfg_start_step;
  logic [STEP_WIDTH-1:0]  cfg_stop_step;
  logic [STEP_WIDTH-1:0]  cfg_inc;
  logic [DWELL_WIDTH-1:0] cfg_dwell;
  logic [STEP_WIDTH-1:0]  cfg_range;
  logic [1:0]             cfg_mode;
  logic                   start;
  logic                   abort;
  logic [STEP_WIDTH-1:0]  step_out;
  logic [STEP_WIDTH-1:0]  range_out;
  logic                   step_update;
  logic                   busy;
  logic                   done;
  logic [COUNT_WIDTH-1:0] sweep_count;

  modport master (
    output cfg_start_step, cfg_stop_step, cfg_inc, cfg_dwell, cfg_range, cfg_mode,
    output start, abort,
    input  step_out, range_out, step_update, busy, done, sweep_count
  );

  modport slave (
    input  cfg_start_step, cfg_stop_step, cfg_inc, cfg_dwell, cfg_range, cfg_mode,
    input  start, abort,
    output step_out, range_out, step_update, busy, done, sweep_count
  );

endinterface

// File: rtl/wavegen_dwell_timer.sv
// Dwell countdown: a load holds the current step for max(value,1) cycles,
// expire_o is high on the last hold cycle.
module wavegen_dwell_timer #(
  parameter int DWELL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_i,
  input  logic [DWELL_WIDTH-1:0] value_i,
  output logic                   expire_o
);

  logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = (value_i == '0) ? '0 : value_i - DWELL_WIDTH'(1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - DWELL_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/wavegen_sweep_ctrl.sv
// Frequency-sweep scheduler: walks step from start to stop in inc increments,
// holding each value for the dwell time, in single/repeat/triangle modes.
module wavegen_sweep_ctrl
  import wavegen_pkg::*;
#(
  parameter int STEP_WIDTH  = STEP_WIDTH_DEF,
  parameter int DWELL_WIDTH = 16,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  wavegen_sweep_ctrl_if.slave bus
);

  localparam int SW = STEP_WIDTH;

  state_e                 state_q, state_d;
  mode_e                  mode_q, mode_d;
  logic [SW-1:0]          step_q, step_d;
  logic [SW-1:0]          range_q, range_d;
  logic [SW-1:0]          start_q, start_d;
  logic [SW-1:0]          stop_q, stop_d;
  logic [SW-1:0]          inc_q, inc_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
  logic                   down_q, down_d;
  logic                   upd_q, upd_d;
  logic                   done_q, done_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

  logic                   tmr_load, tmr_expire;
  logic [DWELL_WIDTH-1:0] tmr_val;

  // One extra bit catches wrap past the top of the step range and
  // borrow below zero.
  logic [SW:0] up_sum, dn_diff;
  logic        up_ok, dn_ok;

  assign up_sum  = {1'b0, step_q} + {1'b0, inc_q};
  assign dn_diff = {1'b0, step_q} - {1'b0, inc_q};
  assign up_ok   = (up_sum <= {1'b0, stop_q});
  assign dn_ok   = !dn_diff[SW] && (dn_diff[SW-1:0] >= start_q);

  wavegen_dwell_timer #(.DWELL_WIDTH(DWELL_WIDTH)) u_dwell (
    .clk      (clk),
    .reset    (reset),
    .load_i   (tmr_load),
    .value_i  (tmr_val),
    .expire_o (tmr_expire)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    step_d   = step_q;
    range_d  = range_q;
    start_d  = start_q;
    stop_d   = stop_q;
    inc_d    = inc_q;
    dwell_d  = dwell_q;
    down_d   = down_q;
    cnt_d    = cnt_q;
    upd_d    = 1'b0;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = dwell_q;

    if (bus.abort) begin
      state_d = ST_IDLE;
      step_d  = '0;
      upd_d   = (step_q != '0);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            start_d  = bus.cfg_start_step;
            stop_d   = bus.cfg_stop_step;
            inc_d    = bus.cfg_inc;
            dwell_d  = bus.cfg_dwell;
            mode_d   = decode_mode(bus.cfg_mode);
            range_d  = bus.cfg_range;
            step_d   = bus.cfg_start_step;
            down_d   = 1'b0;
            cnt_d    = '0;
            upd_d    = 1'b1;
            state_d  = ST_RUN;
            tmr_load = 1'b1;
            tmr_val  = bus.cfg_dwell;
          end
        end
        default: begin
          // inc of zero is a constant tone: no advance, no strobe.
          if (tmr_expire && (inc_q != '0)) begin
            tmr_load = 1'b1;
            upd_d    = 1'b1;
            if (!down_q && up_ok) begin
              step_d = up_sum[SW-1:0];
            end else if (!down_q && dn_ok && (mode_q == MODE_UPDOWN)) begin
              step_d = dn_diff[SW-1:0];
              down_d = 1'b1;
            end else if (down_q && dn_ok) begin
              step_d = dn_diff[SW-1:0];
            end else begin
              cnt_d = cnt_q + COUNT_WIDTH'(1);
              case (mode_q)
                MODE_REPEAT: step_d = start_q;
                MODE_UPDOWN: begin
                  // step_q sits at start here; a too-narrow span re-emits start.
                  down_d = 1'b0;
                  step_d = up_ok ? up_sum[SW-1:0] : start_q;
                end
                default: begin
                  state_d  = ST_IDLE;
                  upd_d    = 1'b0;
                  done_d   = 1'b1;
                  tmr_load = 1'b0;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_SINGLE;
      step_q  <= '0;
      range_q <= '0;
      start_q <= '0;
      stop_q  <= '0;
      inc_q   <= '0;
      dwell_q <= '0;
      down_q  <= 1'b0;
      upd_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      step_q  <= step_d;
      range_q <= range_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      inc_q   <= inc_d;
      dwell_q <= dwell_d;
      down_q  <= down_d;
      upd_q   <= upd_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.step_out    = step_q;
  assign bus.range_out   = range_q;
  assign bus.step_update = upd_q;
  assign bus.busy        = (state_q == ST_RUN);
  assign bus.done        = done_q;
  assign bus.sweep_count = cnt_q;

endmodule

// File: tb/tb_wavegen_sweep_ctrl.sv
// Directed bench for wavegen_sweep_ctrl: a sequence-index model checked every
// cycle, plus literal expectations at hand-computed cycles.
module tb_wavegen_sweep_ctrl;

  localparam int SW = 12;
  localparam int DW = 16;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wavegen_sweep_ctrl_if #(.STEP_WIDTH(SW), .DWELL_WIDTH(DW), .COUNT_WIDTH(CW)) bus ();

  wavegen_sweep_ctrl #(.STEP_WIDTH(SW), .DWELL_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the sweep is the arithmetic list start + k*inc (k = 0..n-1);
  // modes walk an index over that list.
  bit m_valid = 0;
  bit m_busy, m_upd, m_done, m_left0;
  int m_step, m_range, m_cnt, m_hold, m_idx, m_n;
  int s_start, s_inc, s_dwell, s_mode;

  function automatic int val(input int k);
    return s_start + k * s_inc;
  endfunction

  task automatic emit(input int v);
    m_step = v;
    m_upd  = 1;
    m_hold = (s_dwell == 0) ? 1 : s_dwell;
  endtask

  always @(posedge clk) begin
    m_upd  = 0;
    m_done = 0;
    if (reset) begin
      m_valid = 1; m_busy = 0; m_step = 0; m_range = 0; m_cnt = 0;
    end else if (bus.abort) begin
      if (m_step != 0) m_upd = 1;
      m_step = 0;
      m_busy = 0;
    end else if (!m_busy) begin
      if (bus.start) begin
        s_start = int'(bus.cfg_start_step);
        s_inc   = int'(bus.cfg_inc);
        s_dwell = int'(bus.cfg_dwell);
        s_mode  = (bus.cfg_mode == 2'd3) ? 0 : int'(bus.cfg_mode);
        if (s_inc == 0 || s_start > int'(bus.cfg_stop_step)) m_n = 1;
        else m_n = (int'(bus.cfg_stop_step) - s_start) / s_inc + 1;
        m_busy = 1; m_idx = 0; m_left0 = 0; m_cnt = 0;
        m_range = int'(bus.cfg_range);
        emit(s_start);
      end
    end else if (s_inc != 0) begin
      m_hold--;
      if (m_hold == 0) begin
        if (s_mode == 0) begin
          if (m_idx + 1 < m_n) begin m_idx++; emit(val(m_idx)); end
          else begin m_busy = 0; m_done = 1; m_cnt++; end
        end else if (s_mode == 1) begin
          m_idx = (m_idx + 1) % m_n;
          if (m_idx == 0) m_cnt++;
          emit(val(m_idx));
        end else if (m_n == 1) begin
          m_cnt++;
          emit(s_start);
        end else begin
          // Triangle period 2n-2; every departure from start but the first ends a cycle.
          if (m_idx == 0) begin
            if (m_left0) m_cnt++;
            m_left0 = 1;
          end
          m_idx = (m_idx + 1) % (2 * m_n - 2);
          emit(val((m_idx < m_n) ? m_idx : (2 * m_n - 2 - m_idx)));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("step_out",    int'(bus.step_out),    m_step);
      chk("range_out",   int'(bus.range_out),   m_range);
      chk("step_update", int'(bus.step_update), int'(m_upd));
      chk("busy",        int'(bus.busy),        int'(m_busy));
      chk("done",        int'(bus.done),        int'(m_done));
      chk("sweep_count", int'(bus.sweep_count), m_cnt % (1 << CW));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int s, input int p, input int i, input int d, input int m, input int r);
    bus.cfg_start_step = SW'(s);
    bus.cfg_stop_step  = SW'(p);
    bus.cfg_inc        = SW'(i);
    bus.cfg_dwell      = DW'(d);
    bus.cfg_mode       = 2'(m);
    bus.cfg_range      = SW'(r);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
  endtask

  task automatic pulse_abort();
    bus.abort = 1'b1; tick(); bus.abort = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("rst_step", int'(bus.step_out), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_cnt",  int'(bus.sweep_count), 0);

    // SINGLE 100..130 by 10, dwell 3
    set_cfg(100, 130, 10, 3, 0, 55);
    pulse_start();                       // T+1
    chk("single_t1",  int'(bus.step_out), 100);
    chk("single_upd", int'(bus.step_update), 1);
    repeat (3) tick();                   // T+4
    chk("single_t4", int'(bus.step_out), 110);
    repeat (6) tick();                   // T+10
    chk("single_t10", int'(bus.step_out), 130);
    repeat (3) tick();                   // T+13
    chk("single_done", int'(bus.done), 1);
    chk("single_busy", int'(bus.busy), 0);
    chk("single_hold", int'(bus.step_out), 130);
    chk("single_cnt",  int'(bus.sweep_count), 1);
    tick();
    pulse_abort();                       // abort from IDLE with a tone held
    chk("idle_abort_step",  int'(bus.step_out), 0);
    chk("idle_abort_upd",   int'(bus.step_update), 1);
    chk("idle_abort_range", int'(bus.range_out), 55);

    // REPEAT 0..25 by 10, dwell 1; a second start mid-sweep is ignored
    set_cfg(0, 25, 10, 1, 1, 7);
    pulse_start();                       // T+1: 0
    tick(); tick(); tick();              // T+4
    chk("rep_wrap", int'(bus.step_out), 0);
    chk("rep_cnt1", int'(bus.sweep_count), 1);
    set_cfg(200, 300, 1, 5, 0, 9);
    pulse_start();                       // T+5
    chk("rep_ign", int'(bus.step_out), 10);
    repeat (3) tick();                   // T+8
    chk("rep_cnt2", int'(bus.sweep_count), 2);
    chk("rep_t8", int'(bus.step_out), 10);
    pulse_abort();                       // T+9
    chk("rep_abort_step", int'(bus.step_out), 0);
    chk("rep_abort_busy", int'(bus.busy), 0);

    // UPDOWN 10..40 by 10, dwell 2
    set_cfg(10, 40, 10, 2, 2, 3);
    pulse_start();                       // T+1
    repeat (13) tick();                  // T+14: second 10
    chk("ud_t14",  int'(bus.step_out), 10);
    chk("ud_cnt0", int'(bus.sweep_count), 0);
    tick();                              // T+15
    chk("ud_t15",  int'(bus.step_out), 20);
    chk("ud_cnt1", int'(bus.sweep_count), 1);
    repeat (20) tick();
    pulse_abort();

    // Overflow of start+inc, dwell 0
    set_cfg(4090, 4095, 8, 0, 0, 1);
    pulse_start();
    chk("ovf_t1", int'(bus.step_out), 4090);
    tick();
    chk("ovf_done", int'(bus.done), 1);
    chk("ovf_hold", int'(bus.step_out), 4090);

    // inc = 0: constant tone until abort
    set_cfg(4090, 4095, 0, 5, 1, 1);
    pulse_start();
    repeat (20) tick();
    chk("inc0_step", int'(bus.step_out), 4090);
    chk("inc0_busy", int'(bus.busy), 1);
    chk("inc0_cnt",  int'(bus.sweep_count), 0);
    pulse_abort();

    // Reserved mode runs as SINGLE: 5,10,15,20 then done at T+5
    set_cfg(5, 20, 5, 1, 3, 2);
    pulse_start();
    repeat (4) tick();
    chk("rsv_done", int'(bus.done), 1);

    // start > stop in REPEAT, then UPDOWN: single value re-emitted every dwell
    set_cfg(50, 20, 3, 2, 1, 0);
    pulse_start();                       // T+1
    repeat (6) tick();                   // T+7
    chk("deg_rep_cnt", int'(bus.sweep_count), 3);
    pulse_abort();
    set_cfg(50, 20, 3, 2, 2, 0);
    pulse_start();
    repeat (7) tick();
    pulse_abort();
    set_cfg(10, 15, 10, 1, 2, 0);        // span narrower than inc
    pulse_start();
    repeat (5) tick();
    pulse_abort();
    set_cfg(10, 20, 10, 1, 2, 0);        // two-point triangle
    pulse_start();
    repeat (7) tick();
    pulse_abort();

    // start and abort together in IDLE
    bus.start = 1'b1; bus.abort = 1'b1; tick(); bus.start = 1'b0; bus.abort = 1'b0;
    chk("race_busy", int'(bus.busy), 0);
    chk("race_upd",  int'(bus.step_update), 0);

    // cfg change mid-sweep, then reset at step 120
    set_cfg(100, 130, 10, 3, 0, 55);
    pulse_start();                       // T+1
    set_cfg(7, 4000, 1, 9, 1, 99);
    repeat (6) tick();                   // T+7
    chk("cfgchg_t7", int'(bus.step_out), 120);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mrst_step",  int'(bus.step_out), 0);
    chk("mrst_range", int'(bus.range_out), 0);
    chk("mrst_done",  int'(bus.done), 0);
    chk("mrst_busy",  int'(bus.busy), 0);
    set_cfg(100, 130, 10, 3, 0, 55);
    pulse_start();
    chk("post_rst_t1", int'(bus.step_out), 100);
    repeat (14) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
